// File: rtl/onehot_dec_pkg.sv
// Shared types for the streaming binary-to-one-hot decoder: buffer entry,
// buffer depth and occupancy encoding.
package onehot_dec_pkg;

    // Upper bound on NUM_BITS; entries carry this many one-hot bits and the
    // top level uses only the low NUM_BITS of them.
    localparam int MAX_ONEHOT_BITS = 64;
    localparam int BUF_DEPTH       = 2;

    typedef logic [1:0] occ_t;

    typedef struct packed {
        logic [MAX_ONEHOT_BITS-1:0] onehot;
        logic                       err;
    } entry_t;

endpackage

// File: rtl/dec_buf2.sv
// Two-entry register FIFO. The head entry register drives the output directly,
// so the consumer always sees registered data.
module dec_buf2
    import onehot_dec_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    entry_t slot0_reg;
    entry_t slot1_reg;
    occ_t   occ_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_reg <= '0;
            slot1_reg <= '0;
            occ_reg   <= '0;
        end else begin
            case (occ_reg)
                2'd0: begin
                    if (push) begin
                        slot0_reg <= din;
                        occ_reg   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        slot0_reg <= din;
                    end else if (push) begin
                        slot1_reg <= din;
                        occ_reg   <= 2'd2;
                    end else if (pop) begin
                        // Clear the head so an empty buffer presents all-zero data.
                        slot0_reg <= '0;
                        occ_reg   <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        slot0_reg <= slot1_reg;
                        slot1_reg <= '0;
                        occ_reg   <= 2'd1;
                    end
                end
                default: begin
                    occ_reg <= '0;
                end
            endcase
        end
    end

    assign dout  = slot0_reg;
    assign full  = (occ_reg == occ_t'(BUF_DEPTH));
    assign empty = (occ_reg == 2'd0);

endmodule

// File: rtl/onehot_decoder_stream.sv
// Streaming binary-index to one-hot decoder with valid/ready on both sides,
// a two-entry output buffer and a saturating out-of-range counter.
module onehot_decoder_stream
    import onehot_dec_pkg::*;
#(
    parameter int NUM_BITS     = 16,
    parameter int IN_BITS      = 4,
    parameter int ERR_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_BITS-1:0]      binary_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_BITS-1:0]     decoder_out,
    output logic                    out_err,
    output logic [ERR_CNT_BITS-1:0] err_count,
    input  logic                    err_clear
);

    logic                    push;
    logic                    pop;
    logic                    buf_full;
    logic                    buf_empty;
    logic                    code_oor;
    logic                    bad_accept;
    logic [NUM_BITS-1:0]     dec_word;
    entry_t                  din;
    entry_t                  dout;
    logic [ERR_CNT_BITS-1:0] err_count_reg;
    logic                    unused_hi;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !buf_full;
    assign out_valid = !buf_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign code_oor   = (32'(binary_in) >= NUM_BITS);
    assign dec_word   = NUM_BITS'(1) << binary_in;
    assign bad_accept = push && enable && code_oor;

    always_comb begin
        din = '0;
        if (enable) begin
            if (code_oor) begin
                din.err = 1'b1;
            end else begin
                din.onehot = MAX_ONEHOT_BITS'(dec_word);
            end
        end
    end

    dec_buf2 u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign decoder_out = dout.onehot[NUM_BITS-1:0];
    assign out_err     = dout.err;
    assign unused_hi   = ^dout.onehot;

    // A clear coinciding with a bad accept lands on 1 so that event is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (err_clear) begin
            err_count_reg <= bad_accept ? ERR_CNT_BITS'(1) : '0;
        end else if (bad_accept && (err_count_reg != {ERR_CNT_BITS{1'b1}})) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign err_count = err_count_reg;

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed bench: a default 16-bit instance for decode/stream/backpressure and
// a 10-bit instance for out-of-range codes and the saturating error counter.
module tb_onehot_decoder_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  binary_in = '0;
    logic        out_ready = 1'b0;
    logic        err_clear = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] decoder_out;
    logic        out_err;
    logic [7:0]  err_count;

    logic        in_valid10 = 1'b0;
    logic        in_ready10;
    logic        out_valid10;
    logic [9:0]  decoder_out10;
    logic        out_err10;
    logic [7:0]  err_count10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_decoder_stream u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .binary_in   (binary_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .decoder_out (decoder_out),
        .out_err     (out_err),
        .err_count   (err_count),
        .err_clear   (err_clear)
    );

    onehot_decoder_stream #(.NUM_BITS(10), .IN_BITS(4), .ERR_CNT_BITS(8)) u_dut10 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid10),
        .in_ready    (in_ready10),
        .binary_in   (binary_in),
        .out_valid   (out_valid10),
        .out_ready   (out_ready),
        .decoder_out (decoder_out10),
        .out_err     (out_err10),
        .err_count   (err_count10),
        .err_clear   (err_clear)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_decoder_out", 32'(decoder_out), 32'd0);
        check_val("rst_out_err", 32'(out_err), 32'd0);
        check_val("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single code 5
        enable = 1'b1; binary_in = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("single_valid", 32'(out_valid), 32'd1);
        check_val("single_data", 32'(decoder_out), 32'h0020);
        check_val("single_err", 32'(out_err), 32'd0);
        check_val("single_cnt", 32'(err_count), 32'd0);
        tick();
        check_val("single_drained", 32'(out_valid), 32'd0);

        // Back-to-back 0..15
        in_valid = 1'b1; binary_in = 4'd0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_val($sformatf("stream_data_%0d", k), 32'(decoder_out), 32'd1 << k);
            check_val($sformatf("stream_rdy_%0d", k), 32'({out_valid, in_ready}), 32'b11);
            if (k < 15) binary_in = 4'(k + 1);
            else in_valid = 1'b0;
        end
        tick();
        check_val("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure with codes 3, 7, 9
        out_ready = 1'b0; in_valid = 1'b1; binary_in = 4'd3;
        tick();
        binary_in = 4'd7;
        tick();
        binary_in = 4'd9;
        check_val("bp_full_ready", 32'(in_ready), 32'd0);
        check_val("bp_hold0", 32'(decoder_out), 32'h0008);
        tick();
        check_val("bp_hold1", 32'(decoder_out), 32'h0008);
        check_val("bp_stall_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check_val("bp_out1", 32'(decoder_out), 32'h0080);
        check_val("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("bp_out2", 32'(decoder_out), 32'h0200);
        check_val("bp_out2_valid", 32'(out_valid), 32'd1);
        tick();
        check_val("bp_drained", 32'(out_valid), 32'd0);

        // Enable low
        enable = 1'b0; binary_in = 4'd12; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; enable = 1'b1;
        check_val("en0_valid", 32'(out_valid), 32'd1);
        check_val("en0_data", 32'(decoder_out), 32'd0);
        check_val("en0_err", 32'(out_err), 32'd0);
        check_val("en0_cnt", 32'(err_count), 32'd0);
        tick();

        // Out of range on the 10-bit instance
        in_valid10 = 1'b1; binary_in = 4'd12;
        tick();
        binary_in = 4'd9;
        check_val("oor_data", 32'(decoder_out10), 32'd0);
        check_val("oor_err", 32'(out_err10), 32'd1);
        check_val("oor_cnt", 32'(err_count10), 32'd1);
        tick();
        binary_in = 4'd10;
        check_val("n10_top_data", 32'(decoder_out10), 32'h200);
        check_val("n10_top_err", 32'(out_err10), 32'd0);
        check_val("n10_top_cnt", 32'(err_count10), 32'd1);
        tick();
        check_val("oor_edge_err", 32'(out_err10), 32'd1);
        check_val("oor_edge_cnt", 32'(err_count10), 32'd2);
        binary_in = 4'd15;
        repeat (260) @(posedge clk);
        #1;
        check_val("sat_cnt", 32'(err_count10), 32'd255);
        err_clear = 1'b1;
        tick();
        check_val("clear_with_bad", 32'(err_count10), 32'd1);
        in_valid10 = 1'b0;
        tick();
        err_clear = 1'b0;
        check_val("clear_alone", 32'(err_count10), 32'd0);
        check_val("main_cnt_untouched", 32'(err_count), 32'd0);
        tick();

        // Mid-operation asynchronous reset with two entries buffered
        out_ready = 1'b0; in_valid = 1'b1; binary_in = 4'd2;
        tick();
        binary_in = 4'd4;
        tick();
        in_valid = 1'b0;
        check_val("mr_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("mr_valid", 32'(out_valid), 32'd0);
        check_val("mr_data", 32'(decoder_out), 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("mr_no_stale_%0d", k), 32'({out_valid, decoder_out}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
